fixed_point_div_sched: RTL
==========================

# fixed_point_div_sched

Round-robin scheduler that shares one `fixed_point_div` instance (sign+16.15 operands) between `NREQ` requesters. It accepts one division at a time and holds the operands stable for the divider's full two-register pipeline. It returns the result to the granted requester over a valid/ready response handshake. Zero divisors are short-circuited without touching the divider.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DIV_LAT`, 2: clock edges the divider operands must be held before `out` is valid.
- `DZ_SAT`, 32'h7FFF_FFFF: result returned for a zero divisor.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: request pending, one bit per requester.
- `req_ready`  out  NREQ: one-hot accept.
- `req_a`  in  NREQ x 32: dividend per requester, sign+16.15.
- `req_b`  in  NREQ x 32: divisor per requester, sign+16.15.
- `rsp_valid`  out  NREQ: one-hot response valid, addressed to the granted requester.
- `rsp_data`  out  32: quotient, or `DZ_SAT` for a zero divisor.
- `rsp_dz`  out  1: divide-by-zero flag, qualified by `rsp_valid`.
- `rsp_ready`  in  NREQ: response accept, one bit per requester.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: no operation in progress.
  - WAIT: divider running.
  - RESP: result presented.
- IDLE:
  - If any `req_valid` bit is set, the round-robin arbiter selects index g.
  - `req_ready[g]=1` is combinational in the same cycle.
  - At the edge: latch `op_a=req_a[g]`, `op_b=req_b[g]` and `gnt=g`, and set pointer `rr=g+1` mod NREQ.
  - If `req_b[g]==0`: set `dz=1` and go to RESP.
  - Otherwise: set `dz=0`, clear `cnt`, and go to WAIT.
- Priority: search starts at `rr` and wraps. `rr` resets to 0.
- WAIT:
  - Divider inputs are `op_a` and `op_b`; these registers do not change outside IDLE.
  - `cnt` increments every edge.
  - Go to RESP on the edge where `cnt==DIV_LAT-1`.
- RESP:
  - `rsp_valid[gnt]=1`.
  - `rsp_data` = divider `out`, or `DZ_SAT` when `dz`.
  - `rsp_dz` = `dz`.
  - Operands stay held, so `out` is stable.
  - Go to IDLE on the edge where `rsp_ready[gnt]` is high.
  - `rsp_ready` bits of other requesters are ignored.
- No request is accepted outside IDLE; `req_ready` is all-zero in WAIT and RESP.
- `req_valid` may drop without acceptance with no effect. Requests are never queued.
- Divider internal registers have no reset. Correctness relies only on the full DIV_LAT hold after operands are latched.

## Timing
- Reset values:
  - State IDLE, `rr=0`, `cnt=0`, `op_a=0`, `op_b=0`, `gnt=0`, `dz=0`.
  - `req_ready=0`, `rsp_valid=0`, `rsp_data=0` (forced to 0 outside RESP), `rsp_dz=0`, `busy=0`.
- Normal divide, with the accept cycle as cycle 0:
  - Cycles 1 and 2 are WAIT.
  - `rsp_valid` rises in cycle 3.
  - Minimum issue interval is 4 cycles when the response is taken immediately.
- Zero divisor: `rsp_valid` rises in cycle 1. Minimum interval is 2 cycles.
- A response held by a low `rsp_ready` stalls indefinitely. `rsp_data` stays constant throughout the stall.
- If `rsp_ready[gnt]` is already high when RESP is entered, the handshake completes on the first RESP edge. IDLE is then entered and a new accept is possible in the next cycle.
- Reset asserted mid-operation:
  - The in-flight operation is dropped with no response.
  - All outputs go to reset values immediately (asynchronously).
- Simultaneous requests: exactly one grant per accept cycle. A requester that has just been served has the lowest priority on the next arbitration.

## Structure
- Package `fixed_point_div_sched_pkg`:
  - State enum `sched_state_t` {IDLE, WAIT, RESP}.
  - `Q_I=16`, `Q_F=15`.
  - `DZ_SAT`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req` and pointer.
  - Outputs: one-hot `gnt` and its index.
  - Purely combinational.
- Contains one instance of `fixed_point_div`, with the top-level `clk` and `reset` passed through.

## Test plan
- Reset, then a single request on index 1 with a=32'h0000_8000, b=32'h0001_0000 -> `req_ready=4'b0010` in the accept cycle. `rsp_valid=4'b0010` exactly 3 cycles later. `rsp_data` equals a standalone `fixed_point_div` golden model with the operands held 2 cycles. `rsp_dz=0`.
- Zero divisor: index 0 with a=32'h0001_0000, b=0 -> `rsp_valid=4'b0001` one cycle after accept, `rsp_data=32'h7FFF_FFFF`, `rsp_dz=1`, no divider wait.
- All four requesters valid continuously, `rsp_ready` tied high -> grant order 0,1,2,3,0. Accepts every 4 cycles. Each `rsp_data` matches the golden model for its own operands.
- Response stall: `rsp_ready` low for 10 cycles in RESP -> `rsp_valid` and `rsp_data` constant, `busy=1`, `req_ready=0` despite other pending `req_valid`. Release -> IDLE on that edge, next grant the following cycle.
- Wrong-port ready: in RESP for index 2, assert `rsp_ready=4'b0001` -> no state change. Then `4'b0100` -> handshake completes.
- Reset asserted in cycle 2 of WAIT -> all outputs 0 immediately, no response delivered. After release, the same request is re-accepted with `rr=0` priority.

Source files
------------

// File: rtl/fixed_point_div_sched_pkg.sv
// rtl/fixed_point_div_sched_pkg.sv - shared types and constants for the divider scheduler
package fixed_point_div_sched_pkg;

  // sign+16.15 operand format
  localparam int Q_I = 16;
  localparam int Q_F = 15;
  localparam int W   = 1 + Q_I + Q_F;

  // quotient returned when the divisor is zero
  localparam logic [W-1:0] DZ_SAT = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/fixed_point_div_sched_if.sv
// rtl/fixed_point_div_sched_if.sv - request/response bundle between requesters and the scheduler
interface fixed_point_div_sched_if
  import fixed_point_div_sched_pkg::*;
#(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][W-1:0]  req_a;
  logic [NREQ-1:0][W-1:0]  req_b;
  logic [NREQ-1:0]         rsp_valid;
  logic [W-1:0]            rsp_data;
  logic                    rsp_dz;
  logic [NREQ-1:0]         rsp_ready;
  logic                    busy;

  // requester side
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_dz, busy
  );

  // scheduler side
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_dz, busy
  );

endinterface

// File: rtl/fixed_point_div.sv
// rtl/fixed_point_div.sv - two-register sign-magnitude 16.15 divider
module fixed_point_div
  import fixed_point_div_sched_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_out
);

  localparam int MW = W - 1;
  localparam int NW = MW + Q_F;

  logic [MW-1:0] r_mag_a;
  logic [MW-1:0] r_mag_b;
  logic          r_sign;
  logic [W-1:0]  r_q;

  logic [NW-1:0] w_num;
  logic [NW-1:0] w_den;
  logic [NW-1:0] w_quo;
  logic [MW-1:0] w_mag;

  // stage 1: capture magnitudes and result sign; data registers carry no reset
  always_ff @(posedge clk) begin
    r_mag_a <= i_a[MW-1:0];
    r_mag_b <= i_b[MW-1:0];
    r_sign  <= i_a[W-1] ^ i_b[W-1];
  end

  // magnitude quotient with Q_F fractional bits, saturated to the magnitude range
  always_comb begin
    w_num = {r_mag_a, {Q_F{1'b0}}};
    w_den = NW'(r_mag_b);
    w_quo = (r_mag_b == '0) ? '1 : (w_num / w_den);
    w_mag = (|w_quo[NW-1:MW]) ? '1 : w_quo[MW-1:0];
  end

  // stage 2: register the signed result; a zero magnitude is never reported negative
  always_ff @(posedge clk) begin
    r_q <= {r_sign & (|w_mag), w_mag};
  end

  // keep the uninitialised pipeline from driving the output while in reset
  assign o_out = reset ? '0 : r_q;

endmodule

// File: rtl/fixed_point_div_sched_rr_arbiter.sv
// rtl/fixed_point_div_sched_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic          w_found;
  logic [PW:0]   w_sum;

  // scan from the pointer upward with wrap; the first pending request wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(N)) begin
        w_sum = w_sum - (PW+1)'(N);
      end
      if (!w_found && i_req[w_sum[PW-1:0]]) begin
        w_found                = 1'b1;
        o_gnt[w_sum[PW-1:0]]   = 1'b1;
        o_idx                  = w_sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/fixed_point_div_sched.sv
// rtl/fixed_point_div_sched.sv - round-robin scheduler sharing one fixed-point divider
module fixed_point_div_sched #(
  parameter int          NREQ    = 4,
  parameter int          DIV_LAT = 2,
  parameter logic [31:0] DZ_SAT  = fixed_point_div_sched_pkg::DZ_SAT
) (
  input  logic                      clk,
  input  logic                      reset,
  fixed_point_div_sched_if.slave    bus
);

  import fixed_point_div_sched_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DIV_LAT + 1);

  sched_state_t   r_state;
  sched_state_t   w_next;

  logic [PW-1:0]  r_rr;
  logic [PW-1:0]  r_gnt;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_op_a;
  logic [W-1:0]   r_op_b;
  logic           r_dz;

  logic [NREQ-1:0] w_arb_gnt;
  logic [PW-1:0]   w_arb_idx;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic [W-1:0]    w_div_out;
  logic            w_accept;
  logic            w_sel_dz;
  logic            w_wait_done;
  logic            w_rsp_done;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_rr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  // operands come only from the held registers so the divider sees them unchanged
  fixed_point_div u_div (
    .clk   (clk),
    .reset (reset),
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .o_out (w_div_out)
  );

  assign w_sel_a     = bus.req_a[w_arb_idx];
  assign w_sel_b     = bus.req_b[w_arb_idx];
  assign w_sel_dz    = (w_sel_b == '0);
  assign w_accept    = (r_state == IDLE) && (|bus.req_valid);
  assign w_wait_done = (r_cnt == CW'(DIV_LAT - 1));
  assign w_rsp_done  = bus.rsp_ready[r_gnt];

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state: zero divisors skip the divider wait entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_sel_dz ? RESP : WAIT;
      WAIT: if (w_wait_done) w_next = RESP;
      RESP: if (w_rsp_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // accept-time latching of operands, grant and pointer; wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr   <= '0;
      r_gnt  <= '0;
      r_cnt  <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_op_a <= w_sel_a;
      r_op_b <= w_sel_b;
      r_gnt  <= w_arb_idx;
      r_rr   <= (w_arb_idx == PW'(NREQ - 1)) ? '0 : (w_arb_idx + PW'(1));
      r_dz   <= w_sel_dz;
      r_cnt  <= '0;
    end else if (r_state == WAIT) begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // outputs: grants only in IDLE outside reset, response only in RESP
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    bus.rsp_dz    = 1'b0;
    bus.busy      = (r_state != IDLE);
    case (r_state)
      IDLE: if (!reset) bus.req_ready = w_arb_gnt;
      RESP: begin
        bus.rsp_valid = NREQ'(1) << r_gnt;
        bus.rsp_data  = r_dz ? DZ_SAT : w_div_out;
        bus.rsp_dz    = r_dz;
      end
      default: ;
    endcase
  end

endmodule
